lcd_stream_timing_gen: RTL and testbench

//  Streaming LCD frame driver: generates VSYNC/HSYNC/DE timing and consumes a valid/ready pixel stream, PPC pixels per clock.

---
 rtl/lcd_stream_timing_gen.sv | 117 +++++++++++
 tb/tb_lcd_stream_timing_gen.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/lcd_stream_timing_gen.sv
// lcd_stream_timing_gen: LCD VSYNC/HSYNC/DE timing from shadowed cfg, PPC-wide valid/ready pixel stream in, registered strobes/adjusted pixels/status out
module lcd_stream_timing_gen #(
  parameter int PIX_W   = 8,
  parameter int PPC     = 2,
  parameter int W_SIZE  = 12,
  parameter int W_DELAY = 12,
  parameter int W_FCNT  = 16
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic                   cfg_start,
  input  logic                   cfg_continuous,
  input  logic [W_SIZE-1:0]      cfg_width,
  input  logic [W_SIZE-1:0]      cfg_height,
  input  logic [W_DELAY-1:0]     cfg_vsync_cycle,
  input  logic [W_DELAY-1:0]     cfg_vsync_delay,
  input  logic [W_DELAY-1:0]     cfg_hsync_delay,
  input  logic [W_DELAY-1:0]     cfg_frame_gap,
  input  logic [1:0]             cfg_br_mode,
  input  logic [PIX_W-1:0]       cfg_br_value,
  input  logic                   cfg_clr_underflow,
  input  logic                   in_valid,
  input  logic [PPC*3*PIX_W-1:0] in_data,
  output logic                   in_ready,
  output logic                   out_vsync,
  output logic                   out_hsync,
  output logic                   out_de,
  output logic [PPC*3*PIX_W-1:0] out_data,
  output logic                   out_frame_start,
  output logic                   out_frame_done,
  output logic                   out_underflow,
  output logic                   out_busy,
  output logic [W_SIZE-1:0]      out_row,
  output logic [W_FCNT-1:0]      out_frame_cnt
);
  localparam int DW = PPC*3*PIX_W;
  localparam int CW = W_SIZE > W_DELAY ? W_SIZE : W_DELAY;
  typedef enum logic [2:0] {IDLE, VSYNC, VBP, HBP, ACTIVE, GAP} state_t;
  state_t st;
  logic [W_DELAY-1:0] sh_vs, sh_vbp, sh_hbp, sh_gap;
  logic [W_SIZE-1:0] sh_width, sh_height, beats;
  logic sh_cont;
  logic [1:0] sh_mode;
  logic [PIX_W-1:0] sh_val, p;
  logic [PIX_W:0] s, d;
  logic [CW-1:0] cnt, raw, len;
  logic last, last_row, load, gap_end;
  logic [DW-1:0] adj;
  assign in_ready = st == ACTIVE;
  always_comb begin
    beats = sh_width / W_SIZE'(PPC);
    raw = st == VSYNC ? CW'(sh_vs) : st == VBP ? CW'(sh_vbp) : st == HBP ? CW'(sh_hbp) :
          st == ACTIVE ? CW'(beats) : CW'(sh_gap);
    len = raw == '0 ? CW'(1) : raw;
    last = cnt == len - CW'(1);
    last_row = sh_height == '0 || out_row == sh_height - W_SIZE'(1);
    gap_end = st == GAP && last;
    load = (st == IDLE && cfg_start) || (gap_end && sh_cont && cfg_start);
  end
  always_comb begin
    adj = '0;
    p = '0;
    s = '0;
    d = '0;
    for (int k = 0; k < PPC*3; k++) begin
      p = in_data[k*PIX_W +: PIX_W];
      s = {1'b0, p} + {1'b0, sh_val};
      d = {1'b0, p} - {1'b0, sh_val};
      adj[k*PIX_W +: PIX_W] = sh_mode == 2'b01 ? (s[PIX_W] ? '1 : s[PIX_W-1:0]) :
                              sh_mode == 2'b10 ? (d[PIX_W] ? '0 : d[PIX_W-1:0]) :
                              sh_mode == 2'b11 ? ~p : p;
    end
  end
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      {sh_vs, sh_vbp, sh_hbp, sh_gap} <= '0;
      {sh_width, sh_height, sh_cont, sh_mode, sh_val} <= '0;
    end else if (load) begin
      sh_vs <= cfg_vsync_cycle;
      sh_vbp <= cfg_vsync_delay;
      sh_hbp <= cfg_hsync_delay;
      sh_gap <= cfg_frame_gap;
      sh_width <= cfg_width;
      sh_height <= cfg_height;
      sh_cont <= cfg_continuous;
      sh_mode <= cfg_br_mode;
      sh_val <= cfg_br_value;
    end
  end
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      st <= IDLE;
      cnt <= '0;
      {out_vsync, out_hsync, out_de, out_frame_start, out_frame_done, out_underflow, out_busy} <= '0;
      out_data <= '0;
      out_row <= '0;
      out_frame_cnt <= '0;
    end else begin
      cnt <= (st == IDLE || last) ? '0 : cnt + CW'(1);
      out_vsync <= st == VSYNC;
      out_hsync <= st == HBP;
      out_de <= st == ACTIVE;
      out_data <= (st == ACTIVE && in_valid) ? adj : '0;
      out_underflow <= (st == ACTIVE && !in_valid) || (out_underflow && !cfg_clr_underflow);
      out_busy <= st != IDLE;
      out_frame_start <= load;
      out_frame_done <= gap_end;
      out_frame_cnt <= gap_end ? out_frame_cnt + W_FCNT'(1) : out_frame_cnt;
      out_row <= load ? '0 : (st == ACTIVE && last && !last_row) ? out_row + W_SIZE'(1) : out_row;
      if (load)
        st <= VSYNC;
      else if (st != IDLE && last)
        st <= st == VSYNC ? VBP : st == VBP ? HBP : st == HBP ? ACTIVE :
              st == ACTIVE ? (last_row ? GAP : HBP) : IDLE;
    end
  end
endmodule

// File: tb/tb_lcd_stream_timing_gen.sv
// tb_lcd_stream_timing_gen: directed self-checking bench for lcd_stream_timing_gen
module tb_lcd_stream_timing_gen;
  logic HCLK = 0, HRESET = 1, cfg_start = 0, cfg_continuous = 0, cfg_clr_underflow = 0, in_valid = 1;
  logic [11:0] cfg_width = 8, cfg_height = 2;
  logic [11:0] cfg_vsync_cycle = 2, cfg_vsync_delay = 1, cfg_hsync_delay = 3, cfg_frame_gap = 4;
  logic [1:0] cfg_br_mode = 0;
  logic [7:0] cfg_br_value = 0;
  logic [47:0] in_data = 48'h1E12C8_FA0A00;
  logic in_ready, out_vsync, out_hsync, out_de, out_frame_start, out_frame_done, out_underflow, out_busy;
  logic [47:0] out_data;
  logic [11:0] out_row;
  logic [15:0] out_frame_cnt;
  int n_chk = 0, n_fail = 0;
  int n_vs, n_hs, n_de, n_rdy, n_fs, n_fd, t_fs, t_fd, n_bad;
  bit to;
  logic [47:0] de_data [64];
  logic de_uf [64];
  lcd_stream_timing_gen dut (
    .HCLK(HCLK), .HRESET(HRESET), .cfg_start(cfg_start), .cfg_continuous(cfg_continuous),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_vsync_cycle(cfg_vsync_cycle),
    .cfg_vsync_delay(cfg_vsync_delay), .cfg_hsync_delay(cfg_hsync_delay), .cfg_frame_gap(cfg_frame_gap),
    .cfg_br_mode(cfg_br_mode), .cfg_br_value(cfg_br_value), .cfg_clr_underflow(cfg_clr_underflow),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .out_vsync(out_vsync),
    .out_hsync(out_hsync), .out_de(out_de), .out_data(out_data), .out_frame_start(out_frame_start),
    .out_frame_done(out_frame_done), .out_underflow(out_underflow), .out_busy(out_busy),
    .out_row(out_row), .out_frame_cnt(out_frame_cnt)
  );
  always #5 HCLK = ~HCLK;
  task automatic cfg_common();
    cfg_continuous = 0; cfg_width = 8; cfg_height = 2; cfg_vsync_cycle = 2; cfg_vsync_delay = 1;
    cfg_hsync_delay = 3; cfg_frame_gap = 4; cfg_br_mode = 0; cfg_br_value = 0; in_valid = 1;
    in_data = 48'h1E12C8_FA0A00;
  endtask
  task automatic watch(input int drop_n, input int drop_beat, input int chg_at);
    n_vs = 0; n_hs = 0; n_de = 0; n_rdy = 0; n_fs = 0; n_fd = 0; t_fs = -1; t_fd = -1; n_bad = 0; to = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge HCLK);
      if (out_vsync) n_vs++;
      if (out_hsync) n_hs++;
      if (out_de) begin
        if (n_de < 64) begin de_data[n_de] = out_data; de_uf[n_de] = out_underflow; end
        n_de++;
      end
      if (!out_de && out_data != 0) n_bad++;
      if (out_frame_start) begin if (n_fs == 0) t_fs = c; n_fs++; end
      if (out_frame_done) begin t_fd = c; n_fd++; end
      if (n_fs >= drop_n) cfg_start = 0;
      if (c == chg_at) cfg_width = 16;
      in_valid = !(in_ready && n_rdy == drop_beat);
      if (in_ready) n_rdy++;
      if (n_fd > 0 && !out_busy) return;
    end
    to = 1;
  endtask
  task automatic test_reset();
    HRESET = 1;
    repeat (3) @(negedge HCLK);
    n_chk++; if ({out_vsync, out_hsync, out_de, out_frame_start, out_frame_done, out_underflow, out_busy, in_ready} !== 8'd0) begin n_fail++; $display("FAIL reset_strobes: got %b required 0", {out_vsync, out_hsync, out_de, out_frame_start, out_frame_done, out_underflow, out_busy, in_ready}); end
    n_chk++; if (out_data !== 48'd0 || out_row !== 12'd0 || out_frame_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_regs: data %h row %0d cnt %0d required 0", out_data, out_row, out_frame_cnt); end
    HRESET = 0;
  endtask
  task automatic test_timing();
    logic [15:0] fc0;
    @(negedge HCLK); cfg_common(); fc0 = out_frame_cnt; cfg_start = 1;
    watch(1, -1, -1);
    n_chk++; if (to !== 1'b0) begin n_fail++; $display("FAIL t1_timeout: got %0d required 0", to); end
    n_chk++; if (t_fd - t_fs !== 21) begin n_fail++; $display("FAIL t1_frame_len: got %0d required 21", t_fd - t_fs); end
    n_chk++; if (n_vs !== 2 || n_hs !== 6) begin n_fail++; $display("FAIL t1_sync: vs %0d hs %0d required 2 6", n_vs, n_hs); end
    n_chk++; if (n_de !== 8 || n_rdy !== 8) begin n_fail++; $display("FAIL t1_de_ready: de %0d rdy %0d required 8 8", n_de, n_rdy); end
    n_chk++; if (n_fs !== 1 || n_fd !== 1) begin n_fail++; $display("FAIL t1_pulses: fs %0d fd %0d required 1 1", n_fs, n_fd); end
    n_chk++; if (out_frame_cnt !== fc0 + 16'd1) begin n_fail++; $display("FAIL t1_frame_cnt: got %0d required %0d", out_frame_cnt, fc0 + 16'd1); end
    n_chk++; if (out_busy !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL t1_idle: busy %b ready %b required 0 0", out_busy, in_ready); end
    n_chk++; if (n_bad !== 0) begin n_fail++; $display("FAIL t1_data_off_de: got %0d required 0", n_bad); end
    n_chk++; if (de_data[0] !== 48'h1E12C8_FA0A00) begin n_fail++; $display("FAIL t1_bypass: got %h required 1e12c8fa0a00", de_data[0]); end
  endtask
  task automatic test_brightness();
    logic [47:0] exp_v [4];
    exp_v[0] = 48'h1E12C8_FA0A00; exp_v[1] = 48'h463AF0_FF3228;
    exp_v[2] = 48'h0000A0_D20000; exp_v[3] = 48'hE1ED37_05F5FF;
    for (int m = 0; m < 4; m++) begin
      @(negedge HCLK); cfg_common(); cfg_br_mode = 2'(m); cfg_br_value = (m == 3) ? 8'd99 : 8'd40; cfg_start = 1;
      watch(1, -1, -1);
      n_chk++; if (de_data[0] !== exp_v[m]) begin n_fail++; $display("FAIL t2_mode%0d_first: got %h required %h", m, de_data[0], exp_v[m]); end
      n_chk++; if (de_data[7] !== exp_v[m]) begin n_fail++; $display("FAIL t2_mode%0d_last: got %h required %h", m, de_data[7], exp_v[m]); end
    end
  endtask
  task automatic test_underflow();
    @(negedge HCLK); cfg_common(); cfg_start = 1;
    watch(1, 2, -1);
    n_chk++; if (de_data[2] !== 48'd0 || de_uf[2] !== 1'b1) begin n_fail++; $display("FAIL t3_drop_beat: data %h uf %b required 0 1", de_data[2], de_uf[2]); end
    n_chk++; if (de_uf[1] !== 1'b0 || de_data[3] !== 48'h1E12C8_FA0A00) begin n_fail++; $display("FAIL t3_neighbours: uf1 %b data3 %h required 0 1e12c8fa0a00", de_uf[1], de_data[3]); end
    n_chk++; if (n_de !== 8 || t_fd - t_fs !== 21) begin n_fail++; $display("FAIL t3_no_stall: de %0d len %0d required 8 21", n_de, t_fd - t_fs); end
    n_chk++; if (out_underflow !== 1'b1) begin n_fail++; $display("FAIL t3_sticky: got %b required 1", out_underflow); end
    cfg_clr_underflow = 1; @(negedge HCLK); cfg_clr_underflow = 0;
    n_chk++; if (out_underflow !== 1'b0) begin n_fail++; $display("FAIL t3_clear: got %b required 0", out_underflow); end
  endtask
  task automatic test_continuous();
    logic [15:0] fc0;
    @(negedge HCLK); cfg_common(); cfg_continuous = 1; fc0 = out_frame_cnt; cfg_start = 1;
    watch(3, -1, -1);
    n_chk++; if (to !== 1'b0 || n_fs !== 3 || n_fd !== 3) begin n_fail++; $display("FAIL t4_frames: to %0d fs %0d fd %0d required 0 3 3", to, n_fs, n_fd); end
    n_chk++; if (t_fd - t_fs !== 63) begin n_fail++; $display("FAIL t4_back_to_back: got %0d required 63", t_fd - t_fs); end
    n_chk++; if (n_de !== 24) begin n_fail++; $display("FAIL t4_de: got %0d required 24", n_de); end
    n_chk++; if (out_frame_cnt !== fc0 + 16'd3) begin n_fail++; $display("FAIL t4_frame_cnt: got %0d required %0d", out_frame_cnt, fc0 + 16'd3); end
    repeat (3) @(negedge HCLK);
    n_chk++; if (out_busy !== 1'b0) begin n_fail++; $display("FAIL t4_idle: got %b required 0", out_busy); end
  endtask
  task automatic test_shadow();
    @(negedge HCLK); cfg_common(); cfg_start = 1;
    watch(1, -1, 5);
    n_chk++; if (n_de !== 8 || t_fd - t_fs !== 21) begin n_fail++; $display("FAIL t5_cur_frame: de %0d len %0d required 8 21", n_de, t_fd - t_fs); end
    @(negedge HCLK); cfg_start = 1;
    watch(1, -1, -1);
    n_chk++; if (n_de !== 16 || t_fd - t_fs !== 29) begin n_fail++; $display("FAIL t5_next_frame: de %0d len %0d required 16 29", n_de, t_fd - t_fs); end
    cfg_width = 8;
  endtask
  task automatic test_reset_mid();
    bit hit = 0;
    int fd_seen = 0;
    @(negedge HCLK); cfg_common(); cfg_start = 1;
    for (int c = 0; c < 100; c++) begin
      @(negedge HCLK); cfg_start = 0;
      if (out_row == 12'd1 && in_ready) begin hit = 1; break; end
    end
    n_chk++; if (hit !== 1'b1) begin n_fail++; $display("FAIL t6_reach_line1: got %0d required 1", hit); end
    HRESET = 1;
    @(negedge HCLK);
    n_chk++; if ({out_vsync, out_hsync, out_de, out_frame_start, out_frame_done, out_underflow, out_busy, in_ready} !== 8'd0) begin n_fail++; $display("FAIL t6_strobes: got %b required 0", {out_vsync, out_hsync, out_de, out_frame_start, out_frame_done, out_underflow, out_busy, in_ready}); end
    n_chk++; if (out_data !== 48'd0 || out_row !== 12'd0 || out_frame_cnt !== 16'd0) begin n_fail++; $display("FAIL t6_regs: data %h row %0d cnt %0d required 0", out_data, out_row, out_frame_cnt); end
    HRESET = 0;
    repeat (30) begin @(negedge HCLK); if (out_frame_done || out_busy) fd_seen++; end
    n_chk++; if (fd_seen !== 0) begin n_fail++; $display("FAIL t6_no_done: got %0d required 0", fd_seen); end
    cfg_start = 1;
    watch(1, -1, -1);
    n_chk++; if (to !== 1'b0 || t_fd - t_fs !== 21 || n_de !== 8) begin n_fail++; $display("FAIL t6_restart: to %0d len %0d de %0d required 0 21 8", to, t_fd - t_fs, n_de); end
    n_chk++; if (out_frame_cnt !== 16'd1) begin n_fail++; $display("FAIL t6_frame_cnt: got %0d required 1", out_frame_cnt); end
  endtask
  initial begin
    test_reset();
    test_timing();
    test_brightness();
    test_underflow();
    test_continuous();
    test_shadow();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
